// File: rtl/m_axi_weight_loader.sv
// AXI4-Lite write-only initiator: splits each 72-bit kernel into three 24-bit words at BASE_ADDR+0x0/0x4/0x8.
// Optional WL_EOB_WRITE_EN: a kernel flagged in_last gets a fourth write of 0 to BASE_ADDR+0xC.
module m_axi_weight_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      m_axi_awaddr,
  output logic [2:0]       m_axi_awprot,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic             busy,
  output logic [CNT_W-1:0] kernel_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B} state_t;

  state_t      state, state_nxt;
  logic [71:0] kern_q;
  logic [1:0]  idx, idx_nxt;
  logic        aw_done, w_done, rdy_q;
  logic        aw_hs, w_hs, b_hs, issue_done, more;

  assign aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign b_hs       = m_axi_bvalid & m_axi_bready;
  assign issue_done = (aw_done | aw_hs) & (w_done | w_hs);
  assign idx_nxt    = idx + 2'd1;

`ifdef WL_EOB_WRITE_EN
  logic last_q;
  // idx 3 is the end-of-batch clear word, only reached for in_last kernels
  assign more = (idx != 2'd3) & ((idx != 2'd2) | last_q);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign more = (idx != 2'd2);
`endif

  assign in_ready     = rdy_q;
  assign busy         = (state != IDLE);
  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb  = 4'b1111;

  function automatic logic [23:0] chunk(input logic [71:0] k, input logic [1:0] i);
    case (i)
      2'd0:    chunk = k[71:48];
      2'd1:    chunk = k[47:24];
      2'd2:    chunk = k[23:0];
      default: chunk = 24'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && rdy_q) state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = WAIT_B;
      WAIT_B:  if (b_hs) state_nxt = more ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      rdy_q         <= 1'b0;
      kern_q        <= '0;
      idx           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      kernel_cnt    <= '0;
      err_cnt       <= '0;
      err           <= 1'b0;
`ifdef WL_EOB_WRITE_EN
      last_q        <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (aw_hs) m_axi_awvalid <= 1'b0;
      if (w_hs)  m_axi_wvalid  <= 1'b0;
      case (state)
        IDLE: if (in_valid && rdy_q) begin
          kern_q        <= in_data;
`ifdef WL_EOB_WRITE_EN
          last_q        <= in_last;
`endif
          idx           <= 2'd0;
          m_axi_awaddr  <= BASE_ADDR;
          m_axi_wdata   <= {8'h00, in_data[71:48]};
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
        end
        ISSUE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if (issue_done) m_axi_bready <= 1'b1;
        end
        WAIT_B: if (b_hs) begin
          m_axi_bready <= 1'b0;
          if (|m_axi_bresp) begin
            err <= 1'b1;
            if (~&err_cnt) err_cnt <= err_cnt + CNT_W'(1);
          end
          // an error response does not abort the kernel
          if (more) begin
            idx           <= idx_nxt;
            m_axi_awaddr  <= BASE_ADDR + {28'd0, idx_nxt, 2'b00};
            m_axi_wdata   <= {8'h00, chunk(kern_q, idx_nxt)};
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end else begin
            kernel_cnt <= kernel_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_m_axi_weight_loader.sv
// Randomized bench for m_axi_weight_loader: queue-based write model, random AXI slave, per-cycle counter compare.
`timescale 1ns/1ps
module tb_m_axi_weight_loader;
  localparam logic [31:0] BASE = 32'h43C0_0000;
  localparam int CW = 16;

  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [71:0] in_data = '0;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic awvalid, wvalid, bready, busy, err;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic [CW-1:0] kernel_cnt, err_cnt;

  always #5 clk = ~clk;

  m_axi_weight_loader #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .busy(busy), .kernel_cnt(kernel_cnt), .err_cnt(err_cnt), .err(err)
  );

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave behaviour knobs
  int p_aw = 100, p_w = 100, p_b = 100, err_pct = 0, w_dly = 0;
  bit err_second = 0, en_cmp = 0;

  // model state
  logic [31:0] exp_a[$], exp_d[$], aw_q[$], w_q[$], log_a[$], log_d[$];
  int len_q[$];
  int acc = 0, done_k = 0, aw_n = 0, w_n = 0, b_n = 0, b_in_k = 0, nw = 0;
  logic [CW-1:0] m_kcnt = '0, m_ecnt = '0;
  bit m_err = 0;
  logic p_awv = 0, p_wv = 0, p_awr = 0, p_wr = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, m_a, m_d;
  logic [23:0] m_ch;

  // monitor/model: samples pre-edge values at each rising edge
  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      exp_a.delete(); exp_d.delete(); aw_q.delete(); w_q.delete();
      log_a.delete(); log_d.delete(); len_q.delete();
      acc = 0; done_k = 0; aw_n = 0; w_n = 0; b_n = 0; b_in_k = 0;
      m_kcnt = '0; m_ecnt = '0; m_err = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
      if (p_awv && p_awr)  chk("aw_drop", awvalid, 0);
      if (p_wv && p_wr)    chk("w_drop", wvalid, 0);
      if (awvalid && !p_awv) chk("aw_w_together", wvalid, 1);
      if (wvalid && !p_wv)   chk("w_aw_together", awvalid, 1);
      if (in_valid && in_ready) begin
        acc++;
        nw = 3;
`ifdef WL_EOB_WRITE_EN
        if (in_last) nw = 4;
`endif
        for (int i = 0; i < nw; i++) begin
          m_ch = (i < 3) ? 24'(in_data >> (24 * (2 - i))) : 24'd0;
          exp_a.push_back(BASE + 32'(4 * i));
          exp_d.push_back({8'h00, m_ch});
        end
        len_q.push_back(nw);
      end
      if (awvalid && awready) begin
        chk("aw_one_outstanding", aw_n, b_n);
        aw_q.push_back(awaddr); aw_n++;
      end
      if (wvalid && wready) begin
        chk("w_one_outstanding", w_n, b_n);
        w_q.push_back(wdata); w_n++;
      end
      while (aw_q.size() > 0 && w_q.size() > 0) begin
        m_a = aw_q.pop_front(); m_d = w_q.pop_front();
        log_a.push_back(m_a); log_d.push_back(m_d);
        chk("write_expected", 64'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) begin
          chk("awaddr", m_a, exp_a.pop_front());
          chk("wdata", m_d, exp_d.pop_front());
        end
      end
      if (bvalid && bready) begin
        if (bresp != 2'b00) begin
          m_err = 1;
          if (m_ecnt != '1) m_ecnt++;
        end
        b_n++; b_in_k++;
        if (len_q.size() > 0 && b_in_k == len_q[0]) begin
          void'(len_q.pop_front());
          b_in_k = 0; done_k++; m_kcnt++;
        end
      end
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
    end
  end

  // per-cycle compare of status outputs against the model
  initial forever begin
    @(negedge clk);
    if (rstn && en_cmp) begin
      chk("kernel_cnt", kernel_cnt, m_kcnt);
      chk("err_cnt", err_cnt, m_ecnt);
      chk("err", err, m_err);
      chk("busy", busy, acc != done_k);
      chk("in_ready", in_ready, acc == done_k);
      chk("awprot", awprot, 3'b000);
      chk("wstrb", wstrb, 4'hF);
    end
  end

  // random AXI-Lite slave, driven on the falling edge
  int s_wcnt = 0, s_bat = 0;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; s_wcnt = 0;
    end else begin
      awready = int'($urandom_range(99)) < p_aw;
      if (!wvalid) s_wcnt = 0;
      if (wvalid && s_wcnt < w_dly) begin wready = 0; s_wcnt++; end
      else wready = int'($urandom_range(99)) < p_w;
      if (bvalid && b_n != s_bat) bvalid = 0;
      if (!bvalid && aw_n > b_n && w_n > b_n && int'($urandom_range(99)) < p_b) begin
        bvalid = 1; s_bat = b_n;
        if (err_second) bresp = (b_in_k == 1) ? 2'b10 : 2'b00;
        else bresp = (int'($urandom_range(99)) < err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
    end
  end

  task automatic send(input logic [71:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("send_timeout", n, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || acc != done_k) && n < 3000) begin @(negedge clk); n++; end
    chk("idle_timeout", n < 3000, 1);
  endtask

  function automatic logic [71:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valids", {awvalid, wvalid, bready, busy, err}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cnts", {kernel_cnt, err_cnt}, 0);
    rstn = 1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    en_cmp = 1;

    // basic kernel
    send(72'hAABBCC_112233_445566, 0);
    wait_idle();
    chk("basic_nwrites", log_a.size(), 3);
    if (log_a.size() >= 3) begin
      chk("basic_a0", log_a[0], 32'h43C00000); chk("basic_d0", log_d[0], 32'h00AABBCC);
      chk("basic_a1", log_a[1], 32'h43C00004); chk("basic_d1", log_d[1], 32'h00112233);
      chk("basic_a2", log_a[2], 32'h43C00008); chk("basic_d2", log_d[2], 32'h00445566);
    end
    chk("basic_kcnt", kernel_cnt, 1);
    chk("basic_busy_err", {busy, err}, 0);

    // wready lags awready by 3 cycles
    w_dly = 3;
    send(rnd72(), 0);
    wait_idle();
    w_dly = 0;
    chk("skew_nwrites", log_a.size(), 6);
    chk("skew_kcnt", kernel_cnt, 2);

    // back-to-back with in_valid held
    for (int k = 0; k < 4; k++) send(rnd72(), 0);
    wait_idle();
    chk("b2b_nwrites", log_a.size(), 18);
    chk("b2b_kcnt", kernel_cnt, 6);
    if (log_a.size() >= 18) chk("b2b_last_addr", log_a[17], 32'h43C00008);

    // SLVERR on the second word
    err_second = 1;
    send(72'h010203_040506_070809, 0);
    wait_idle();
    err_second = 0;
    chk("errresp_nwrites", log_a.size(), 21);
    if (log_a.size() >= 21) chk("errresp_word3", log_d[20], 32'h00070809);
    chk("errresp_err", err, 1);
    chk("errresp_err_cnt", err_cnt, 1);
    chk("errresp_kcnt", kernel_cnt, 7);

    // randomized traffic
    p_aw = 60; p_w = 60; p_b = 70; err_pct = 20;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rnd72(), 1'($urandom_range(1)));
    end
    wait_idle();
    p_aw = 100; p_w = 100; p_b = 100; err_pct = 0;
    chk("rand_kcnt", kernel_cnt, 47);

`ifdef WL_EOB_WRITE_EN
    n = log_a.size();
    send(72'h111111_222222_333333, 1);
    wait_idle();
    chk("eob_nwrites", log_a.size(), n + 4);
    if (log_a.size() >= n + 4) begin
      chk("eob_addr", log_a[n + 3], 32'h43C0000C);
      chk("eob_data", log_d[n + 3], 32'h0);
    end
    chk("eob_kcnt", kernel_cnt, 48);
`endif

    // reset while awvalid is high
    p_aw = 0;
    send(rnd72(), 0);
    n = 0;
    while (!awvalid && n < 50) begin @(negedge clk); n++; end
    chk("midrst_awvalid_before", awvalid, 1);
    en_cmp = 0;
    rstn = 0;
    #1;
    chk("midrst_valids", {awvalid, wvalid, bready}, 0);
    chk("midrst_cnts", {kernel_cnt, err_cnt}, 0);
    chk("midrst_err_busy_rdy", {err, busy, in_ready}, 0);
    @(negedge clk);
    rstn = 1;
    p_aw = 100;
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready, 1);
    en_cmp = 1;
    send(72'hFEDCBA_987654_321000, 0);
    wait_idle();
    chk("midrst_kcnt_after", kernel_cnt, 1);
    chk("midrst_nwrites_after", log_a.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/m_axi_weight_loader.md
Name: m_axi_weight_loader

Overview:
AXI4-Lite write-only initiator that feeds 72-bit convolution kernels into the weight-receiving AXI-Lite slave. Each accepted kernel is split into three 24-bit words and written to offsets 0x0, 0x4 and 0x8 from a base address, one single-beat transaction at a time. A write to offset 0x8 completes a kernel on the slave side. The block sits between the on-chip kernel source (stream handshake) and the AXI interconnect.

Parameters:
BASE_ADDR, 32'h43C0_0000, byte address of the slave's register window (offset 0x0)
CNT_W, 16, width of the kernel and error counters

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  kernel available on in_data
in_ready  output  1  loader can accept a kernel
in_data  input  72  kernel, nine 8-bit elements; [71:48] first word
in_last  input  1  kernel is last of batch; used only with the optional feature
m_axi_awaddr  output  32  write address
m_axi_awprot  output  3  constant 3'b000
m_axi_awvalid  output  1  address valid
m_axi_awready  input  1  address accepted
m_axi_wdata  output  32  {8'h00, 24-bit chunk}
m_axi_wstrb  output  4  constant 4'b1111
m_axi_wvalid  output  1  data valid
m_axi_wready  input  1  data accepted
m_axi_bresp  input  2  write response
m_axi_bvalid  input  1  response valid
m_axi_bready  output  1  loader accepts response
busy  output  1  high whenever state != IDLE
kernel_cnt  output  CNT_W  kernels fully written; wraps modulo 2^CNT_W
err_cnt  output  CNT_W  responses with bresp != 2'b00; saturates at all-ones
err  output  1  sticky: set on any non-OKAY bresp; cleared only by reset

Behaviour:
- Reset values: all valids, bready, busy and err are 0. awaddr, wdata, kernel_cnt and err_cnt are 0. in_ready is 0 during reset and 1 in the first cycle after reset deassertion.
- Reset is asynchronous. Asserting it mid-transaction drops awvalid, wvalid and bready immediately. The partial kernel is discarded.
- All AXI outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_B.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data and in_last, set chunk index idx = 0, then go to ISSUE with awvalid = wvalid = 1 on the next cycle.
- ISSUE:
  - awaddr = BASE_ADDR + 4*idx.
  - wdata = chunk idx: 0 → in_data[71:48], 1 → [47:24], 2 → [23:0].
  - awvalid and wvalid are always raised in the same cycle; the slave requires both at once.
  - Each valid drops independently the cycle after its own handshake.
  - awaddr and wdata stay stable while their valid is high. A valid is never withdrawn before its handshake.
  - Go to WAIT_B once both handshakes are complete, including when both complete in the same cycle.
- WAIT_B:
  - bready = 1.
  - On bvalid, record bresp: if non-zero, set err and increment err_cnt.
  - If idx < 2: idx++ and go to ISSUE, re-raising both valids the next cycle.
  - If idx == 2: increment kernel_cnt and go to IDLE.
- A non-OKAY response does not abort the kernel; the remaining words are still written.
- Only one outstanding transaction at any time. in_ready is low in ISSUE and WAIT_B.
- Minimum kernel time against a slave that responds in one cycle is about 12 cycles. This is not a requirement.
- awaddr arithmetic is 32-bit and wraps silently.

Optional Feature:
Macro WL_EOB_WRITE_EN.
- Defined: after idx 2 completes for a kernel latched with in_last = 1, the loader issues a fourth write to BASE_ADDR+0xC with wdata = 0. This clears the slave's streaming state. kernel_cnt increments only after that response.
- Undefined: in_last is ignored and offset 0xC is never written.

Test Plan:
- Basic kernel: in_data = 72'hAABBCC_112233_445566. Expect writes, in order:
  - 0x43C00000 with 32'h00AABBCC
  - 0x43C00004 with 32'h00112233
  - 0x43C00008 with 32'h00445566
  - Then kernel_cnt = 1, busy = 0, err = 0.
- Skewed ready: slave raises awready 3 cycles before wready. Expect awvalid to drop after its handshake, wvalid and wdata held stable until accepted, and exactly 3 transactions in total.
- Back-to-back: in_valid held high with 4 kernels. Expect 12 writes with ascending offsets 0,4,8 repeated, no overlapping transactions, and kernel_cnt = 4.
- Error response: slave returns bresp = 2'b10 on the second word. Expect the third word still written, err = 1, err_cnt = 1, and kernel_cnt = 1.
- Reset mid-op: assert rstn low while awvalid is high. Expect awvalid, wvalid and bready low in the same cycle, counters at 0, and in_ready = 1 after release.
- With WL_EOB_WRITE_EN, send a kernel with in_last = 1. Expect a fourth write to 0x43C0000C with data 0, and kernel_cnt incremented only after its response.
